// File: rtl/c499_lock_pkg.sv
//==== c499_lock_pkg -- shared widths and FSM state encoding for the c499 lock sequencer (rev 1.0)
`default_nettype none

package c499_lock_pkg;

  localparam int C499_KEY_W  = 52;
  localparam int C499_DATA_W = 32;
  localparam int C499_CHK_W  = 8;
  localparam int C499_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_LOADING = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/c499_lock_seq_if.sv
//==== c499_lock_seq_if -- word stream (source and sink handshakes) around the c499 lock sequencer (rev 1.0)
`default_nettype none

interface c499_lock_seq_if #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              in_corr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_chk,
    output in_corr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_chk,
    input  in_corr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

`default_nettype wire

// File: rtl/c499_key_shreg.sv
//==== c499_key_shreg -- serial key shadow register with bit counter and commit pulse (rev 1.0)
`default_nettype none

module c499_key_shreg
  import c499_lock_pkg::*;
#(
  parameter int KEY_W = C499_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             key_bit,
  output logic             commit,
  output logic [KEY_W-1:0] key_next
);

  localparam int CNT_W = $clog2(KEY_W);

  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;

  assign last_bit = (bit_cnt == CNT_W'(KEY_W - 1));
  assign commit   = shift && last_bit && !clear;

  // Shadow with the current bit already inserted, so the commit edge sees the full key.
  always_comb begin
    key_next          = shadow;
    key_next[bit_cnt] = key_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      shadow  <= key_next;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/c499_lock_seq.sv
//==== c499_lock_seq -- key-load FSM and two-stage valid/ready pipeline in front of the locked c499 core (rev 1.0)
`default_nettype none

module c499_lock_seq
  import c499_lock_pkg::*;
#(
  parameter int KEY_W      = C499_KEY_W,
  parameter int DATA_W     = C499_DATA_W,
  parameter int CHK_W      = C499_CHK_W,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_load_req,
  input  logic                  key_valid,
  input  logic                  key_bit,
  output logic                  key_err,
  output logic                  unlocked,
  c499_lock_seq_if.slave        strm,
  output logic [KEY_W-1:0]      core_key,
  output logic [DATA_W-1:0]     core_id,
  output logic [CHK_W-1:0]      core_ic,
  output logic                  core_r,
  input  logic [DATA_W-1:0]     core_od,
  output logic [C499_CNT_W-1:0] word_cnt
);

  localparam int SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

  state_t            state;
  state_t            state_nxt;
  logic [SET_W-1:0]  settle_cnt;
  logic              settle_done;

  logic              s1_v;
  logic              out_v;
  logic [DATA_W-1:0] out_d;
  logic              in_rdy;
  logic              adv;
  logic              accept;
  logic              move;
  logic              deliver;

  logic              shreg_clear;
  logic              shreg_shift;
  logic              commit;
  logic [KEY_W-1:0]  key_next;

  assign adv     = !out_v || strm.out_ready;
  assign in_rdy  = (state == ST_RUN) && (!s1_v || adv);
  assign accept  = strm.in_valid && in_rdy;
  assign move    = s1_v && adv;
  assign deliver = out_v && strm.out_ready;

  assign strm.in_ready  = in_rdy;
  assign strm.out_valid = out_v;
  assign strm.out_data  = out_d;
  assign unlocked       = (state == ST_RUN);

  // Outside LOADING, and on any restart request, the partial key is discarded.
  assign shreg_clear = (state != ST_LOADING) || key_load_req;
  assign shreg_shift = (state == ST_LOADING) && key_valid;
  assign settle_done = (settle_cnt == SET_W'(SETTLE_CYC));

  c499_key_shreg #(
    .KEY_W (KEY_W)
  ) u_key_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (shreg_clear),
    .shift    (shreg_shift),
    .key_bit  (key_bit),
    .commit   (commit),
    .key_next (key_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOCKED: begin
        if (key_load_req) state_nxt = ST_LOADING;
      end
      ST_LOADING: begin
        if (!key_load_req && commit) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (key_load_req)     state_nxt = ST_LOADING;
        else if (settle_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (key_load_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_v && !out_v) state_nxt = ST_LOADING;
      end
      default: state_nxt = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if ((state == ST_SETTLE) && (state_nxt == ST_SETTLE)) begin
      settle_cnt <= settle_cnt + 1'b1;
    end else begin
      settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key <= '0;
      key_err  <= 1'b0;
    end else begin
      if (commit) core_key <= key_next;
      if (key_valid && (state != ST_LOADING)) key_err <= 1'b1;
    end
  end

  // Stage 1 drives the core inputs directly; they hold their last word when s1 empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      core_id <= '0;
      core_ic <= '0;
      core_r  <= 1'b0;
      out_v   <= 1'b0;
      out_d   <= '0;
    end else begin
      if (accept) begin
        s1_v    <= 1'b1;
        core_id <= strm.in_data;
        core_ic <= strm.in_chk;
        core_r  <= strm.in_corr;
      end else if (move) begin
        s1_v    <= 1'b0;
      end

      if (move) begin
        out_v <= 1'b1;
        out_d <= core_od;
      end else if (strm.out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (deliver) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_c499_lock_seq.sv
//==== tb_c499_lock_seq -- directed bench with a behavioural SEC core and word scoreboard (rev 1.0)
`default_nettype none

module tb_c499_lock_seq;
  import c499_lock_pkg::*;

  localparam int KW = 52;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int SC = 4;
  localparam logic [KW-1:0] KEY_OK   = 52'h9_3C1E_A5F0_7B2D;
  localparam logic [KW-1:0] KEY_ALT  = 52'hC_6A59_0FE3_1D84;
  localparam logic [DW-1:0] SCRAMBLE = 32'h5A3C_96E1;
  localparam logic [DW-1:0] W0       = 32'hA5A5_5A5A;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_load_req = 1'b0;
  logic              key_valid = 1'b0;
  logic              key_bit = 1'b0;
  logic              key_err;
  logic              unlocked;
  logic [KW-1:0]     core_key;
  logic [DW-1:0]     core_id;
  logic [CW-1:0]     core_ic;
  logic              core_r;
  logic [DW-1:0]     core_od;
  logic [15:0]       word_cnt;

  int n_chk = 0;
  int n_fail = 0;

  c499_lock_seq_if #(.DATA_W(DW), .CHK_W(CW)) strm ();

  c499_lock_seq #(
    .KEY_W(KW), .DATA_W(DW), .CHK_W(CW), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_load_req(key_load_req), .key_valid(key_valid),
    .key_bit(key_bit), .key_err(key_err), .unlocked(unlocked), .strm(strm),
    .core_key(core_key), .core_id(core_id), .core_ic(core_ic), .core_r(core_r),
    .core_od(core_od), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference SEC code: data bit i has parity column {i[4:0],111}.
  function automatic logic [CW-1:0] col(int i);
    return {i[4:0], 3'b111};
  endfunction

  function automatic logic [CW-1:0] gen_chk(logic [DW-1:0] d);
    logic [CW-1:0] c = '0;
    for (int i = 0; i < DW; i++) if (d[i]) c ^= col(i);
    return c;
  endfunction

  function automatic logic [DW-1:0] sec(logic [DW-1:0] d, logic [CW-1:0] c, logic r);
    logic [CW-1:0] s = c ^ gen_chk(d);
    logic [DW-1:0] o = d;
    if (r) for (int i = 0; i < DW; i++) if (s == col(i)) o[i] = ~o[i];
    return o;
  endfunction

  // Locked core: wrong key gives scrambled words.
  assign core_od = (core_key == KEY_OK) ? sec(core_id, core_ic, core_r)
                                        : (sec(core_id, core_ic, core_r) ^ SCRAMBLE);

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] sbq[$];
  logic [15:0]   model_cnt = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        model_cnt  = '0;
        prev_stall = 1'b0;
      end else begin
        check("word_cnt_model", 64'(word_cnt), 64'(model_cnt));
        if (prev_stall) begin
          check("stall_valid", 64'(strm.out_valid), 64'd1);
          check("stall_data", 64'(strm.out_data), 64'(prev_data));
        end
        if (strm.in_ready) check("ready_needs_unlocked", 64'(unlocked), 64'd1);
        if (strm.out_valid && strm.out_ready) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_word: got %0h expected no word", strm.out_data);
          end else begin
            check("out_data_order", 64'(strm.out_data), 64'(sbq.pop_front()));
          end
          model_cnt++;
        end
        if (strm.in_valid && strm.in_ready)
          sbq.push_back(sec(strm.in_data, strm.in_chk, strm.in_corr));
        prev_stall = strm.out_valid && !strm.out_ready;
        prev_data  = strm.out_data;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req;
    key_load_req = 1'b1;
    tick();
    key_load_req = 1'b0;
  endtask

  task automatic shift_key(logic [KW-1:0] k, int n, logic [KW-1:0] held);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      check("in_ready_loading", 64'(strm.in_ready), 64'd0);
      if (i == KW - 1) check("core_key_held", 64'(core_key), 64'(held));
      tick();
      if (i == KW - 1) check("core_key_commit", 64'(core_key), 64'(k));
    end
    key_valid = 1'b0;
  endtask

  task automatic settle;
    for (int n = 0; n < SC; n++) begin
      tick();
      check("unlocked_settling", 64'(unlocked), 64'd0);
    end
    tick();
    check("unlocked_after_settle", 64'(unlocked), 64'd1);
    check("in_ready_after_settle", 64'(strm.in_ready), 64'd1);
  endtask

  task automatic send_word(logic [DW-1:0] d, logic [CW-1:0] c, logic r);
    int t = 0;
    strm.in_valid = 1'b1;
    strm.in_data  = d;
    strm.in_chk   = c;
    strm.in_corr  = r;
    #1;
    while (!strm.in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t == 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    tick();
    strm.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_core_key"}, 64'(core_key), 64'd0);
    check({tag, "_core_id"}, 64'(core_id), 64'd0);
    check({tag, "_core_ic_r"}, 64'({core_ic, core_r}), 64'd0);
    check({tag, "_out_data"}, 64'(strm.out_data), 64'd0);
    check({tag, "_flags"}, 64'({strm.out_valid, strm.in_ready, unlocked, key_err}), 64'd0);
    check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] ws [8];
    int idx;
    int cyc;
    logic acc;
    ws = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_0000, 32'h0000_FFFF,
           32'hDEAD_BEEF, 32'h1357_9BDF, 32'h8000_0001, 32'h7FFF_FFFE};
    strm.in_valid = 1'b0; strm.in_data = '0; strm.in_chk = '0;
    strm.in_corr = 1'b0; strm.out_ready = 1'b1;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Key load and settle
    pulse_req();
    shift_key(KEY_OK, KW, '0);
    settle();

    // Single words through the correcting core
    send_word(W0, gen_chk(W0), 1'b1);
    tick();
    check("lat_valid", 64'(strm.out_valid), 64'd1);
    check("clean_word", 64'(strm.out_data), 64'hA5A5_5A5A);
    tick();
    check("word_cnt_1", 64'(word_cnt), 64'd1);
    send_word(W0 ^ 32'h0000_0400, gen_chk(W0), 1'b1);
    tick();
    check("corrected_bit10", 64'(strm.out_data), 64'hA5A5_5A5A);
    tick();
    send_word(W0 ^ 32'h0000_0400, gen_chk(W0), 1'b0);
    tick();
    check("uncorrected_bit10", 64'(strm.out_data), 64'hA5A5_5E5A);
    tick();

    // Back-to-back stream with a toggling sink
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      strm.out_ready = (cyc % 2 == 0);
      strm.in_valid  = 1'b1;
      strm.in_data   = ws[idx] ^ ((idx % 2 == 1) ? (32'd1 << idx) : 32'd0);
      strm.in_chk    = gen_chk(ws[idx]);
      strm.in_corr   = 1'b1;
      #1;
      acc = strm.in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    check("stream_all_accepted", 64'(idx), 64'd8);
    strm.in_valid  = 1'b0;
    strm.out_ready = 1'b1;
    repeat (4) tick();
    check("stream_no_loss", 64'(sbq.size()), 64'd0);
    check("word_cnt_11", 64'(word_cnt), 64'd11);

    // Stray key bit in RUN
    key_valid = 1'b1;
    key_bit   = 1'b1;
    tick();
    key_valid = 1'b0;
    check("key_err_set", 64'(key_err), 64'd1);
    check("still_unlocked", 64'(unlocked), 64'd1);
    check("key_kept", 64'(core_key), 64'(KEY_OK));

    // Reload with two words in flight
    strm.out_ready = 1'b0;
    send_word(32'hCAFE_F00D, gen_chk(32'hCAFE_F00D), 1'b1);
    strm.in_valid = 1'b1;
    strm.in_data  = 32'h0BAD_C0DE ^ 32'h0002_0000;
    strm.in_chk   = gen_chk(32'h0BAD_C0DE);
    strm.in_corr  = 1'b1;
    key_load_req  = 1'b1;
    #1;
    check("accept_with_req", 64'(strm.in_ready), 64'd1);
    tick();
    key_load_req  = 1'b0;
    strm.in_valid = 1'b0;
    check("drain_not_ready", 64'(strm.in_ready), 64'd0);
    check("drain_locked", 64'(unlocked), 64'd0);
    repeat (2) tick();
    strm.out_ready = 1'b1;
    repeat (3) tick();
    check("drain_delivered", 64'(word_cnt), 64'd13);
    check("drain_queue_empty", 64'(sbq.size()), 64'd0);
    shift_key(KEY_ALT, KW, KEY_OK);
    settle();
    check("key_err_sticky", 64'(key_err), 64'd1);

    // Reset in the middle of a key load
    pulse_req();
    tick();
    shift_key(KEY_OK, 30, '0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pulse_req();
    shift_key(KEY_OK, KW, '0);
    settle();
    send_word(W0, gen_chk(W0), 1'b1);
    tick();
    check("post_reset_word", 64'(strm.out_data), 64'hA5A5_5A5A);
    tick();
    check("word_cnt_restart", 64'(word_cnt), 64'd1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
